arbitro_rr4: RTL and testbench
==============================

// Module: arbitro_rr4
// PURPOSE
//  Round-robin arbiter for the 4x4 FIFO switch. Moves words from four
//  first-word-fall-through (FWFT) input FIFOs to four output FIFOs. Routes
//  on a 2-bit destination field carried in each word.
//  Sits between the input-FIFO bank and the output-FIFO bank.
//  Enabled by the top-level control FSM state code.
// PARAMETERS
//  DATA_W     6        word width; dest = data[DATA_W-1:DATA_W-2]
//  ACTIVE_ST  4'b0010  state code that enables arbitration
// PORTS
//  clk          in   1         rising-edge clock
//  reset_L      in   1         asynchronous reset, active low
//  state        in   4         control FSM state code
//  empty        in   4         input FIFO i empty
//  data_in0..3  in   DATA_W    FWFT head word of input FIFO i; valid when !empty[i]
//  almost_full  in   4         output FIFO j almost full; asserted with >=2 free entries
//  pop          out  4         one-hot pop to input FIFO i
//  push         out  4         one-hot push to output FIFO j
//  data_out     out  DATA_W    word written to the output FIFO selected by push
//  gnt_id       out  2         index of the input granted this cycle
// BEHAVIOUR
//  Reset (reset_L=0, async):
//   - pop=0, push=0, data_out=0, gnt_id=0.
//   - rr_ptr=3, so the first search starts at input 0. FSM=OFF.
//  FSM states:
//   - OFF -> RUN when state==ACTIVE_ST.
//   - RUN -> OFF when state!=ACTIVE_ST. Any pop/push already registered completes
//     its cycle; no new grant is issued.
//  Eligibility of input i in a cycle (all must hold):
//   - !empty[i];
//   - !almost_full[dest_i];
//   - !pop[i]. Its head word is stale during the cycle its pop is asserted.
//  Grant (RUN only):
//   - Combinational search over eligible inputs from rr_ptr+1, mod 4 wrap.
//   - At the next clk edge, for the first eligible input k:
//     pop<=1<<k, push<=1<<dest_k, data_out<=data_ink, gnt_id<=k, rr_ptr<=k.
//   - No eligible input: pop=push=0; data_out and gnt_id hold; rr_ptr holds.
//  Latency and throughput:
//   - Decision to pop/push: 1 cycle. pop and push are asserted in the same cycle.
//   - At most one word per cycle.
//   - A single input streams at most every other cycle (stale-head mask).
//  Two inputs sharing a dest are served alternately. Fairness comes from rr_ptr.
//  almost_full rising while a push is registered: that push still completes
//   (slack of 2 covers it). No further grants to that dest.
//  empty rising on the cycle after a pop: no grant to that input; no underflow.
//  At most one bit set in pop and in push at all times.
//  Reset mid-transfer: outputs clear immediately. The in-flight word is dropped.
// CONFIGURATION
//  ARB_GRANT_CNT_EN defined:
//   - Adds output cnt_gnt (4x8 bits, packed {c3,c2,c1,c0}).
//   - Counter i increments on each pop[i] and wraps at 255.
//   - Cleared by reset_L and while FSM=OFF.
//  ARB_GRANT_CNT_EN undefined: no counters, no cnt_gnt port. Behaviour otherwise identical.
// TESTING
//  1 reset_L=0 with random inputs -> pop=push=0, data_out=0, gnt_id=0.
//    Release reset with state=4'b0001 -> outputs stay 0.
//  2 state=ACTIVE_ST, only FIFO0 non-empty, head=6'b01_0101 (dest 1) ->
//    next cycle pop=0001, push=0010, data_out=6'h15. The following cycle pop=0.
//  3 all four FIFOs non-empty, dest 0,1,2,3, no almost_full ->
//    gnt_id sequence 0,1,2,3,0; one push per cycle; push bit matches dest.
//  4 FIFO1 head dest 2, almost_full=0100 ->
//    FIFO1 never granted while other inputs are served. Drop almost_full ->
//    grant to 1 within 4 cycles.
//  5 state leaves ACTIVE_ST in the cycle after a grant ->
//    the registered pop/push completes; then pop=push=0 until state returns.
//  6 with ARB_GRANT_CNT_EN: 300 grants to input 2 -> c2=44;
//    state leaves ACTIVE_ST -> cnt_gnt=0.

Source files
------------

// File: rtl/arbitro_rr4.sv
// Round-robin arbiter moving FWFT input-FIFO words to output FIFOs by 2-bit dest; ARB_GRANT_CNT_EN adds per-input grant counters.
// Latency: 1 cycle from head word presented to registered pop/push; at most one word per cycle.
// Backpressure: an input is skipped while its dest output FIFO is almost_full or its pop is still asserted.
module arbitro_rr4 #(
    parameter int         DATA_W    = 6,
    parameter logic [3:0] ACTIVE_ST = 4'b0010
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [3:0]        state,
    input  logic [3:0]        empty,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic [3:0]        almost_full,
    output logic [3:0]        pop,
    output logic [3:0]        push,
    output logic [DATA_W-1:0] data_out,
`ifdef ARB_GRANT_CNT_EN
    output logic [31:0]       cnt_gnt,
`endif
    output logic [1:0]        gnt_id
);

    typedef enum logic {OFF = 1'b0, RUN = 1'b1} fsm_t;

    fsm_t              fsm;
    logic [1:0]        rr_ptr;
    logic [DATA_W-1:0] din [4];
    logic [3:0]        elig;
    logic              found;
    logic [1:0]        sel;
    logic              grant;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;

    // A head word is stale while its pop is asserted, so it cannot be granted twice in a row.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 4; i++) begin
            elig[i] = !empty[i] && !almost_full[din[i][DATA_W-1 -: 2]] && !pop[i];
        end
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int off = 1; off <= 4; off++) begin
            if (!found && elig[rr_ptr + 2'(off)]) begin
                found = 1'b1;
                sel   = rr_ptr + 2'(off);
            end
        end
    end

    // Grants are issued on every edge that enters or stays in RUN.
    assign grant = found && (state == ACTIVE_ST);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            fsm      <= OFF;
            rr_ptr   <= 2'd3;
            pop      <= '0;
            push     <= '0;
            data_out <= '0;
            gnt_id   <= '0;
        end else begin
            case (fsm)
                OFF: if (state == ACTIVE_ST) fsm <= RUN;
                RUN: if (state != ACTIVE_ST) fsm <= OFF;
                default: fsm <= OFF;
            endcase
            pop  <= '0;
            push <= '0;
            if (grant) begin
                pop      <= 4'b0001 << sel;
                push     <= 4'b0001 << din[sel][DATA_W-1 -: 2];
                data_out <= din[sel];
                gnt_id   <= sel;
                rr_ptr   <= sel;
            end
        end
    end

`ifdef ARB_GRANT_CNT_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_gnt <= '0;
        end else if (fsm == OFF) begin
            cnt_gnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_gnt[8*i +: 8] <= cnt_gnt[8*i +: 8] + {7'd0, pop[i]};
            end
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_rr4.sv
// Bench for arbitro_rr4: directed scenarios plus randomized traffic against a queue scoreboard.
// Latency: a reference model predicts each grant one edge ahead; a monitor checks it on the falling edge.
// Backpressure: random empty/almost_full patterns exercise skipping of blocked and stale inputs.
module tb_arbitro_rr4;

    localparam logic [3:0] ACT = 4'b0010;

    logic       clk = 1'b0;
    logic       reset_L = 1'b1;
    logic [3:0] state = '0;
    logic [3:0] empty = 4'hF;
    logic [5:0] din [4];
    logic [3:0] almost_full = '0;
    logic [3:0] pop;
    logic [3:0] push;
    logic [5:0] data_out;
    logic [1:0] gnt_id;
`ifdef ARB_GRANT_CNT_EN
    logic [31:0] cnt_gnt;
`endif

    arbitro_rr4 #(.DATA_W(6), .ACTIVE_ST(ACT)) dut (
        .clk(clk), .reset_L(reset_L), .state(state), .empty(empty),
        .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
        .almost_full(almost_full), .pop(pop), .push(push), .data_out(data_out),
`ifdef ARB_GRANT_CNT_EN
        .cnt_gnt(cnt_gnt),
`endif
        .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         k;
        logic [3:0] pushv;
        logic [5:0] data;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   m_ptr = 3;
    int   m_last = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: scan inputs in round-robin order after the last winner; skip empty,
    // blocked-dest and just-popped inputs.
    always @(posedge clk) begin
        int   k;
        int   j;
        exp_t e;
        cyc++;
        if (!reset_L) begin
            m_ptr  = 3;
            m_last = -1;
        end else if (state == ACT) begin
            k = -1;
            for (int off = 1; off <= 4; off++) begin
                j = (m_ptr + off) % 4;
                if (k < 0 && !empty[j] && !almost_full[din[j][5:4]] && j != m_last) k = j;
            end
            if (k >= 0) begin
                e.cyc   = cyc;
                e.k     = k;
                e.pushv = 4'(1 << din[k][5:4]);
                e.data  = din[k];
                expq.push_back(e);
                m_ptr = k;
            end
            m_last = k;
        end else begin
            m_last = -1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_L) begin
            if (pop != 4'b0) begin
                if (expq.size() == 0) begin
                    chk("spurious_pop", {28'd0, pop}, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("grant_cycle", cyc, e.cyc);
                    chk("pop", {28'd0, pop}, 32'(1 << e.k));
                    chk("push", {28'd0, push}, {28'd0, e.pushv});
                    chk("data_out", {26'd0, data_out}, {26'd0, e.data});
                    chk("gnt_id", {30'd0, gnt_id}, e.k);
                end
            end else begin
                chk("idle_push", {28'd0, push}, 32'd0);
                if (expq.size() > 0 && expq[0].cyc == cyc) begin
                    e = expq.pop_front();
                    chk("missed_grant", 32'd0, 32'(1 << e.k));
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_pop"}, {28'd0, pop}, 32'd0);
        chk({name, "_push"}, {28'd0, push}, 32'd0);
        chk({name, "_data"}, {26'd0, data_out}, 32'd0);
        chk({name, "_gnt"}, {30'd0, gnt_id}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [5];
        int cnt1;
        int hit;
        for (int i = 0; i < 4; i++) din[i] = 6'($urandom);

        // Reset with random inputs, then idle state code.
        #1 reset_L = 1'b0;
        for (int n = 0; n < 3; n++) begin
            empty = 4'($urandom);
            almost_full = 4'($urandom);
            state = 4'($urandom);
            for (int i = 0; i < 4; i++) din[i] = 6'($urandom);
            tick();
            chk_zero("reset");
        end
        state = 4'b0001;
        reset_L = 1'b1;
        repeat (3) tick();
        chk_zero("idle_state");

        // Single FIFO0 word to dest 1.
        empty = 4'b1110;
        almost_full = 4'b0;
        din[0] = 6'b01_0101;
        state = ACT;
        tick();
        chk("t2_pop", {28'd0, pop}, 32'b0001);
        chk("t2_push", {28'd0, push}, 32'b0010);
        chk("t2_data", {26'd0, data_out}, 32'h15);
        tick();
        chk("t2_pop_next", {28'd0, pop}, 32'd0);
        empty = 4'hF;
        tick();

        // All four busy, dest = index: rotation 0,1,2,3,0.
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = {2'(i), 4'($urandom)};
        empty = 4'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            seq[n] = int'(gnt_id);
            chk("t3_push_dest", {28'd0, push}, 32'(1 << (n % 4)));
        end
        for (int n = 0; n < 5; n++) chk("t3_seq", seq[n], n % 4);

        // Reset mid-transfer clears outputs immediately.
        reset_L = 1'b0;
        #1;
        chk_zero("mid_reset");
        tick();
        reset_L = 1'b1;

        // Blocked dest: FIFO1 targets output 2 which is almost full.
        din[0] = {2'd0, 4'($urandom)};
        din[1] = {2'd2, 4'($urandom)};
        din[2] = {2'd1, 4'($urandom)};
        din[3] = {2'd3, 4'($urandom)};
        almost_full = 4'b0100;
        cnt1 = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (pop[1]) cnt1++;
        end
        chk("t4_blocked_grants", cnt1, 0);
        almost_full = 4'b0;
        hit = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (pop[1]) hit = 1;
        end
        chk("t4_unblocked", hit, 1);

        // Leave ACTIVE_ST right after a grant.
        chk("t5_grant_pending", {31'd0, pop != 4'b0}, 32'd1);
        state = 4'b0001;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("t5_off_pop", {28'd0, pop}, 32'd0);
        end
        state = ACT;
        tick();
        chk("t5_resume", {31'd0, pop != 4'b0}, 32'd1);

        // Randomized traffic, occasional state changes and resets.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 4; i++) din[i] = 6'($urandom);
            empty = 4'($urandom) & 4'($urandom);
            almost_full = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            state = ($urandom_range(0, 15) == 0) ? 4'($urandom) : ACT;
            reset_L = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset_L = 1'b1;
        empty = 4'hF;
        state = ACT;
        repeat (2) tick();

`ifdef ARB_GRANT_CNT_EN
        cnt1 = 0;
        empty = 4'b1011;
        almost_full = 4'b0;
        din[2] = {2'd0, 4'($urandom)};
        for (int n = 0; n < 700 && cnt1 < 300; n++) begin
            tick();
            if (pop[2]) cnt1++;
        end
        empty = 4'hF;
        repeat (2) tick();
        chk("t6_cnt2", {24'd0, cnt_gnt[23:16]}, 32'd44);
        state = 4'b0001;
        repeat (2) tick();
        chk("t6_cnt_clear", cnt_gnt, 32'd0);
`endif

        chk("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
